// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: access size codes, arbiter
// FSM states and the byte-lane mask helper.
package dmem_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        DBG_BURST = 2'd1,
        CPU_SLOT  = 2'd2
    } arb_state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] base;
        case (size)
            SZ_BYTE: base = 4'b0001;
            SZ_HALF: base = 4'b0011;
            SZ_WORD: base = 4'b1111;
            default: base = 4'b0000;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU port, debug-loader port and RAM-side signals of the data-memory arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 17
);
    logic              cpu_req;
    logic              cpu_we;
    logic [1:0]        cpu_size;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic              cpu_err;
    logic [31:0]       cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [1:0]        dbg_size;
    logic [31:0]       dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_lock;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic              dbg_err;
    logic [31:0]       dbg_rdata;

    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-3:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_err, cpu_rdata,
        input  dbg_req, dbg_we, dbg_size, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_err, cpu_rdata,
        output dbg_req, dbg_we, dbg_size, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane handling: store-lane placement, load extraction with
// zero extension, and misalignment / illegal-size detection.
module dmem_lane_align
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  lanes,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [31:0] shifted;

    assign misalign = (size == SZ_ILL)
                   || ((size == SZ_HALF) && offset[0])
                   || ((size == SZ_WORD) && (offset != 2'b00));

    assign lanes   = lane_mask(size, offset);
    assign shifted = rword >> {offset, 3'b000};

    always_comb begin
        case (size)
            SZ_BYTE: wdata_lanes = {4{wdata[7:0]}};
            SZ_HALF: wdata_lanes = {2{wdata[15:0]}};
            default: wdata_lanes = wdata;
        endcase
    end

    always_comb begin
        case (size)
            SZ_BYTE: rdata_ext = {24'h0, shifted[7:0]};
            SZ_HALF: rdata_ext = {16'h0, shifted[15:0]};
            SZ_WORD: rdata_ext = shifted;
            default: rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug loader) arbiter in front of a single-port data RAM.
// Build option DMEM_ARB_RR_EN: round-robin in ARB instead of CPU-first priority.
//
// state     | meaning
// ARB       | normal arbitration between CPU and debug
// DBG_BURST | debug holds the lock; only debug is granted, grants are counted
// CPU_SLOT  | one-cycle window for the CPU after a full debug burst
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 17,
    parameter int MAX_BURST = 8
) (
    input  logic           clk,
    input  logic           NRST,
    dmem_arbiter_if.slave  bus
);

    localparam logic [7:0] MAX_B = MAX_BURST[7:0];

    arb_state_t  state;
    arb_state_t  state_nxt;
    logic [7:0]  burst_cnt;
    logic [7:0]  cnt_upd;
    logic        gnt_cpu;
    logic        gnt_dbg;
    logic        any_gnt;

    logic        sel_we;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_lanes;
    logic [31:0] sel_wlanes;
    logic [31:0] sel_unused_rdata;
    logic        sel_mis;

    logic        pend_rd;
    logic        pend_err;
    logic        pend_dbg;
    logic [1:0]  pend_size;
    logic [1:0]  pend_off;
    logic [31:0] resp_rdata;
    logic [3:0]  resp_unused_lanes;
    logic [31:0] resp_unused_wdata;
    logic        resp_unused_mis;
    logic        unused_bits;

`ifdef DMEM_ARB_RR_EN
    logic ptr_dbg;

    always_ff @(posedge clk) begin
        if (!NRST) begin
            ptr_dbg <= 1'b0;
        end else if ((state == ARB) && ((ptr_dbg && gnt_dbg) || (!ptr_dbg && gnt_cpu))) begin
            ptr_dbg <= !ptr_dbg;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!NRST) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    assign cnt_upd = (gnt_dbg && (burst_cnt < MAX_B)) ? burst_cnt + 8'd1 : burst_cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            ARB: begin
                if (gnt_dbg && bus.dbg_lock) state_nxt = DBG_BURST;
            end
            DBG_BURST: begin
                if (!bus.dbg_req || !bus.dbg_lock)        state_nxt = ARB;
                else if ((cnt_upd >= MAX_B) && bus.cpu_req) state_nxt = CPU_SLOT;
            end
            CPU_SLOT: state_nxt = ARB;
            default:  state_nxt = ARB;
        endcase
    end

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_dbg = 1'b0;
        if (NRST) begin
            case (state)
                ARB: begin
`ifdef DMEM_ARB_RR_EN
                    if (ptr_dbg) begin
                        if (bus.dbg_req)      gnt_dbg = 1'b1;
                        else if (bus.cpu_req) gnt_cpu = 1'b1;
                    end else begin
                        if (bus.cpu_req)      gnt_cpu = 1'b1;
                        else if (bus.dbg_req) gnt_dbg = 1'b1;
                    end
`else
                    if (bus.cpu_req)      gnt_cpu = 1'b1;
                    else if (bus.dbg_req) gnt_dbg = 1'b1;
`endif
                end
                DBG_BURST: gnt_dbg = bus.dbg_req && !((burst_cnt >= MAX_B) && bus.cpu_req);
                CPU_SLOT:  gnt_cpu = bus.cpu_req;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!NRST || (state_nxt != DBG_BURST)) begin
            burst_cnt <= 8'd0;
        end else if (state == ARB) begin
            burst_cnt <= 8'd1;
        end else begin
            burst_cnt <= cnt_upd;
        end
    end

    assign any_gnt   = gnt_cpu || gnt_dbg;
    assign sel_we    = gnt_dbg ? bus.dbg_we    : bus.cpu_we;
    assign sel_size  = gnt_dbg ? bus.dbg_size  : bus.cpu_size;
    assign sel_addr  = gnt_dbg ? bus.dbg_addr  : bus.cpu_addr;
    assign sel_wdata = gnt_dbg ? bus.dbg_wdata : bus.cpu_wdata;

    dmem_lane_align u_align_req (
        .size        (sel_size),
        .offset      (sel_addr[1:0]),
        .wdata       (sel_wdata),
        .rword       (32'h0),
        .lanes       (sel_lanes),
        .wdata_lanes (sel_wlanes),
        .rdata_ext   (sel_unused_rdata),
        .misalign    (sel_mis)
    );

    assign bus.cpu_gnt   = gnt_cpu;
    assign bus.dbg_gnt   = gnt_dbg;
    assign bus.ram_en    = any_gnt && !sel_mis;
    assign bus.ram_we    = (bus.ram_en && sel_we) ? sel_lanes : 4'b0000;
    assign bus.ram_addr  = any_gnt ? sel_addr[ADDR_W-1:2] : '0;
    assign bus.ram_wdata = (bus.ram_en && sel_we) ? sel_wlanes : 32'h0;

    always_ff @(posedge clk) begin
        if (!NRST) begin
            pend_rd   <= 1'b0;
            pend_err  <= 1'b0;
            pend_dbg  <= 1'b0;
            pend_size <= SZ_BYTE;
            pend_off  <= 2'b00;
        end else begin
            pend_rd   <= any_gnt && !sel_we && !sel_mis;
            pend_err  <= any_gnt && sel_mis;
            pend_dbg  <= gnt_dbg;
            pend_size <= sel_size;
            pend_off  <= sel_addr[1:0];
        end
    end

    dmem_lane_align u_align_resp (
        .size        (pend_size),
        .offset      (pend_off),
        .wdata       (32'h0),
        .rword       (bus.ram_rdata),
        .lanes       (resp_unused_lanes),
        .wdata_lanes (resp_unused_wdata),
        .rdata_ext   (resp_rdata),
        .misalign    (resp_unused_mis)
    );

    // Responses are masked during reset; a read granted just before reset is dropped.
    assign bus.cpu_rvalid = NRST && pend_rd && !pend_dbg;
    assign bus.dbg_rvalid = NRST && pend_rd && pend_dbg;
    assign bus.cpu_err    = NRST && pend_err && !pend_dbg;
    assign bus.dbg_err    = NRST && pend_err && pend_dbg;
    assign bus.cpu_rdata  = bus.cpu_rvalid ? resp_rdata : 32'h0;
    assign bus.dbg_rdata  = bus.dbg_rvalid ? resp_rdata : 32'h0;

    assign unused_bits = ^{sel_addr[31:ADDR_W], sel_unused_rdata, resp_unused_lanes,
                           resp_unused_wdata, resp_unused_mis};

endmodule
